// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, maximum instruction length, fetch FSM states.
package y86_pkg;

    localparam int INSTR_BYTES = 10;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] IIADDQ  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_len_decode.sv
// Combinational Y86-64 instruction length from icode; unknown icodes are treated as one byte.
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len
);

    always_comb begin
        len = 4'd1;
        case (icode)
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:      len = 4'd2;
            IJXX, ICALL:                       len = 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ, IIADDQ: len = 4'd10;
            default:                           len = 4'd1;
        endcase
    end

endmodule

// File: rtl/ifetch_byte_loader.sv
// Byte-serial loader of the 10-byte instruction window at pc into ibytes.
// Define SHORT_FETCH_EN to stop loading once the decoded instruction length is reached.
module ifetch_byte_loader
    import y86_pkg::*;
#(
    parameter logic [63:0] MEM_BYTES = 64'd8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] pc,
    output logic        busy,
    output logic        done,
    output logic [79:0] ibytes,
    output logic        imem_error,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata
);

    localparam logic [3:0] FULL_LEN = 4'(INSTR_BYTES);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [3:0]   k_q, k_d;
    logic [3:0]   len_q, len_d;
    logic [79:0]  ibytes_q, ibytes_d;
    logic         err_q, err_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         req_q, req_d;
    logic [63:0]  addr_q, addr_d;
    logic [3:0]   dec_len;
    logic [3:0]   limit;
    logic [3:0]   k_next;
    logic [63:0]  a_next;
    logic         a_next_ok;

`ifdef SHORT_FETCH_EN
    instr_len_decode u_len (
        .icode (mem_rdata[7:4]),
        .len   (dec_len)
    );
`else
    assign dec_len = FULL_LEN;
`endif

    // Length is known from byte 0 as it arrives; later slots use the stored value.
    assign limit     = (k_q == 4'd0) ? dec_len : len_q;
    assign k_next    = k_q + 4'd1;
    assign a_next    = pc_q + {60'd0, k_next};
    assign a_next_ok = (a_next >= pc_q) && (a_next < MEM_BYTES);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        k_d      = k_q;
        len_d    = len_q;
        ibytes_d = ibytes_q;
        err_d    = err_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        req_d    = req_q;
        addr_d   = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d     = pc;
                    k_d      = 4'd0;
                    len_d    = FULL_LEN;
                    ibytes_d = '0;
                    if (pc >= MEM_BYTES) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        req_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        req_d   = 1'b1;
                        addr_d  = pc;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                // Skipped slots (no request) complete in one cycle and stay zero.
                if (!req_q || mem_ready) begin
                    if (req_q) begin
                        for (int i = 0; i < INSTR_BYTES; i++) begin
                            if (k_q == 4'(i)) ibytes_d[8*i +: 8] = mem_rdata;
                        end
                    end
                    if (k_q == 4'd0) len_d = dec_len;
                    if (k_next >= limit) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        req_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        k_d   = k_next;
                        req_d = a_next_ok;
                        if (a_next_ok) addr_d = a_next;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            k_q      <= '0;
            len_q    <= FULL_LEN;
            ibytes_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            k_q      <= k_d;
            len_q    <= len_d;
            ibytes_q <= ibytes_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ibytes     = ibytes_q;
    assign imem_error = err_q;
    assign mem_req    = req_q;
    assign mem_addr   = addr_q;

endmodule

// File: tb/tb_ifetch_byte_loader.sv
// Directed bench for ifetch_byte_loader: a 8 KiB instance plus a full-64-bit instance for wrap checks.
module tb_ifetch_byte_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [63:0] pc_a, pc_b;
    logic        mem_ready;

    logic        a_busy, a_done, a_err, a_req;
    logic [79:0] a_ibytes;
    logic [63:0] a_addr;
    logic [7:0]  a_rdata;
    logic        b_busy, b_done, b_err, b_req;
    logic [79:0] b_ibytes;
    logic [63:0] b_addr;
    logic [7:0]  b_rdata;

    logic [7:0]  mem [0:8191];

    int          tests = 0;
    int          fails = 0;
    int          cyc, nreq, stall_left, waited;
    logic [63:0] stall_addr;
    logic [63:0] addr_log [0:15];

`ifdef SHORT_FETCH_EN
    localparam int          NOP_CYC  = 2;
    localparam int          NOP_REQ  = 1;
    localparam logic [79:0] NOP_BYTES = 80'h10;
`else
    localparam int          NOP_CYC  = 11;
    localparam int          NOP_REQ  = 10;
    localparam logic [79:0] NOP_BYTES = 80'h5510;
`endif

    always #5 clk = ~clk;

    assign a_rdata = (a_addr < 64'd8192) ? mem[a_addr[12:0]] : 8'h00;
    assign b_rdata = {4'h3, b_addr[3:0]};

    ifetch_byte_loader #(.MEM_BYTES(64'd8192)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pc(pc_a),
        .busy(a_busy), .done(a_done), .ibytes(a_ibytes), .imem_error(a_err),
        .mem_req(a_req), .mem_addr(a_addr), .mem_ready(mem_ready), .mem_rdata(a_rdata)
    );

    ifetch_byte_loader #(.MEM_BYTES(64'hFFFF_FFFF_FFFF_FFFF)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pc(pc_b),
        .busy(b_busy), .done(b_done), .ibytes(b_ibytes), .imem_error(b_err),
        .mem_req(b_req), .mem_addr(b_addr), .mem_ready(mem_ready), .mem_rdata(b_rdata)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a fetch, then run until done, logging every accepted request.
    task automatic run_fetch(input bit use_b, input logic [63:0] p);
        if (use_b) begin pc_b = p; start_b = 1'b1; end
        else       begin pc_a = p; start_a = 1'b1; end
        mem_ready = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        cyc  = 1;
        nreq = 0;
        while (!(use_b ? b_done : a_done) && cyc < 40) begin
            if (!use_b && stall_left > 0 && a_req && a_addr == stall_addr) begin
                mem_ready = 1'b0;
                stall_left--;
                check("stall_addr_hold", a_addr, stall_addr);
            end else begin
                mem_ready = 1'b1;
            end
            if ((use_b ? b_req : a_req) && mem_ready) begin
                if (nreq < 16) addr_log[nreq] = use_b ? b_addr : a_addr;
                nreq++;
            end
            step();
            cyc++;
        end
        mem_ready = 1'b1;
        check("done_seen", use_b ? b_done : a_done, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[16'h100] = 8'h30; mem[16'h101] = 8'hF2; mem[16'h102] = 8'h08;
        mem[8190]    = 8'h60; mem[8191]    = 8'h01;
        mem[16'h300] = 8'h10; mem[16'h301] = 8'h55;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        pc_a = '0; pc_b = '0; mem_ready = 1'b1;
        stall_left = 0; stall_addr = '0;
        step();
        step();
        check("rst_busy",   a_busy,   1'b0);
        check("rst_done",   a_done,   1'b0);
        check("rst_req",    a_req,    1'b0);
        check("rst_addr",   a_addr,   64'h0);
        check("rst_ibytes", a_ibytes, 80'h0);
        check("rst_err",    a_err,    1'b0);
        rst = 1'b0;
        step();

        // Basic fetch of irmovq at 0x100
        run_fetch(1'b0, 64'h100);
        check("t1_cycles", cyc, 11);
        check("t1_reqs",   nreq, 10);
        check("t1_addr0",  addr_log[0], 64'h100);
        check("t1_addr5",  addr_log[5], 64'h105);
        check("t1_addr9",  addr_log[9], 64'h109);
        check("t1_lo16",   a_ibytes[15:0], 16'hF230);
        check("t1_ibytes", a_ibytes, 80'h08F230);
        check("t1_err",    a_err, 1'b0);
        check("t1_busy_at_done", a_busy, 1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("t1_done_pulse", a_done, 1'b0);
        check("t1_start_in_done_busy", a_busy, 1'b0);
        check("t1_start_in_done_req",  a_req,  1'b0);
        check("t1_ibytes_hold", a_ibytes, 80'h08F230);
        step();

        // Same fetch, three wait cycles on byte 4
        stall_left = 3; stall_addr = 64'h104;
        run_fetch(1'b0, 64'h100);
        check("t2_cycles", cyc, 14);
        check("t2_reqs",   nreq, 10);
        check("t2_ibytes", a_ibytes, 80'h08F230);
        stall_left = 0;
        step();
        step();

        // Out-of-range pc
        run_fetch(1'b0, 64'd8192);
        check("t3_cycles", cyc, 1);
        check("t3_reqs",   nreq, 0);
        check("t3_err",    a_err, 1'b1);
        check("t3_ibytes", a_ibytes, 80'h0);
        step();
        check("t3_err_hold", a_err, 1'b1);
        step();

        // Two bytes left before the end of memory
        run_fetch(1'b0, 64'd8190);
        check("t4_cycles", cyc, 11);
        check("t4_reqs",   nreq, 2);
        check("t4_addr1",  addr_log[1], 64'd8191);
        check("t4_ibytes", a_ibytes, 80'h0160);
        check("t4_err",    a_err, 1'b0);
        step();
        step();

        // 64-bit wrap: only the slots below 2^64-1 are requested
        run_fetch(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_cycles", cyc, 11);
        check("t5_reqs",   nreq, 3);
        check("t5_addr0",  addr_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_addr2",  addr_log[2], 64'hFFFF_FFFF_FFFF_FFFE);
        check("t5_ibytes", b_ibytes, 80'h3E3D3C);
        check("t5_err",    b_err, 1'b0);
        step();
        step();

        // Reset during byte 5, then refetch
        pc_a = 64'h100; start_a = 1'b1;
        step();
        start_a = 1'b0;
        waited = 0;
        while (!(a_req && a_addr == 64'h105) && waited < 20) begin
            step();
            waited++;
        end
        check("t6_reach_byte5", a_addr, 64'h105);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_busy",   a_busy,   1'b0);
        check("t6_req",    a_req,    1'b0);
        check("t6_ibytes", a_ibytes, 80'h0);
        check("t6_done",   a_done,   1'b0);
        step();
        run_fetch(1'b0, 64'h100);
        check("t6_re_addr0",  addr_log[0], 64'h100);
        check("t6_re_reqs",   nreq, 10);
        check("t6_re_ibytes", a_ibytes, 80'h08F230);
        step();
        step();

        // One-byte nop: short fetch stops after byte 0
        run_fetch(1'b0, 64'h300);
        check("t7_cycles", cyc, NOP_CYC);
        check("t7_reqs",   nreq, NOP_REQ);
        check("t7_ibytes", a_ibytes, NOP_BYTES);
        check("t7_err",    a_err, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
